// File: rtl/pdm_audio_pkg.sv
// rtl/pdm_audio_pkg.sv - shared widths, default timing and PCM helpers for the PDM audio transmitter
package pdm_audio_pkg;

  localparam int PCM_W           = 16;
  localparam int BIT_DIV_DEFAULT = 32;
  localparam int OSR_DEFAULT     = 64;
  localparam int INT_W           = 20;
  localparam int CNT_W           = 9;

  function automatic logic [PCM_W-1:0] to_offset_binary(input logic [PCM_W-1:0] s);
    return {~s[PCM_W-1], s[PCM_W-2:0]};
  endfunction

endpackage

// File: rtl/pdm_audio_tx_sigma_delta.sv
// rtl/pdm_audio_tx_sigma_delta.sv - delta-sigma modulator (module pdm_sigma_delta)
// Second order when PDM_TX_ORDER2_EN is defined, first-order carry accumulator otherwise.
module pdm_sigma_delta
  import pdm_audio_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             bit_stb,
  input  logic [PCM_W-1:0] sample,
  output logic             pdm_bit
);

  logic pdm_q, pdm_d;

`ifdef PDM_TX_ORDER2_EN
  localparam int SW = INT_W + 2;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (INT_W-1)) - 1);
  localparam logic signed [SW-1:0] FB_MAG  = SW'(1 <<< (PCM_W-1));

  function automatic logic signed [INT_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SAT_MAX) return INT_W'(SAT_MAX);
    if (v < -SAT_MAX) return INT_W'(-SAT_MAX);
    return INT_W'(v);
  endfunction

  logic signed [INT_W-1:0] i1_q, i1_d, i2_q, i2_d, i1_nxt, i2_nxt;
  logic signed [SW-1:0]    fb, sum1, sum2;

  always_comb begin
    fb     = pdm_q ? FB_MAG : -FB_MAG;
    sum1   = SW'(i1_q) + SW'(signed'(sample)) - fb;
    i1_nxt = sat(sum1);
    sum2   = SW'(i2_q) + SW'(i1_nxt) - fb;
    i2_nxt = sat(sum2);
    i1_d   = i1_q;
    i2_d   = i2_q;
    pdm_d  = pdm_q;
    if (clr) begin
      i1_d  = '0;
      i2_d  = '0;
      pdm_d = 1'b0;
    end else if (bit_stb) begin
      i1_d  = i1_nxt;
      i2_d  = i2_nxt;
      pdm_d = ~i2_nxt[INT_W-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i1_q  <= '0;
      i2_q  <= '0;
      pdm_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      pdm_q <= pdm_d;
    end
  end
`else
  logic [PCM_W-1:0] acc_q, acc_d;
  logic [PCM_W:0]   sum;

  // The carry out of the offset-binary accumulator is the PDM bit.
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, to_offset_binary(sample)};
    acc_d = acc_q;
    pdm_d = pdm_q;
    if (clr) begin
      acc_d = '0;
      pdm_d = 1'b0;
    end else if (bit_stb) begin
      acc_d = sum[PCM_W-1:0];
      pdm_d = sum[PCM_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      pdm_q <= pdm_d;
    end
  end
`endif

  assign pdm_bit = pdm_q;

endmodule

// File: rtl/pdm_audio_tx.sv
// rtl/pdm_audio_tx.sv - PCM-to-PDM audio transmitter top: timing, double buffer, flags
// Modulator order chosen by PDM_TX_ORDER2_EN (undefined: first order).
module pdm_audio_tx
  import pdm_audio_pkg::*;
#(
  parameter int BIT_DIV = BIT_DIV_DEFAULT,
  parameter int OSR     = OSR_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [PCM_W-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pdm_out,
  output logic             aud_sd,
  output logic             underflow,
  input  logic             underflow_clr
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0] OSR_LAST = CNT_W'(OSR - 1);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, osr_cnt_q, osr_cnt_d;
  logic [PCM_W-1:0] hold_reg_q, hold_reg_d, act_reg_q, act_reg_d;
  logic             hold_full_q, hold_full_d;
  logic             underflow_q, underflow_d;
  logic             aud_sd_q, aud_sd_d;
  logic             bit_stb, smp_stb, ready, handshake;

  assign bit_stb   = (bit_cnt_q == BIT_LAST);
  assign smp_stb   = bit_stb && (osr_cnt_q == OSR_LAST);
  assign ready     = enable && !hold_full_q && !reset;
  assign handshake = sample_valid && ready;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    osr_cnt_d   = osr_cnt_q;
    hold_reg_d  = hold_reg_q;
    hold_full_d = hold_full_q;
    act_reg_d   = act_reg_q;
    aud_sd_d    = enable;
    underflow_d = underflow_q;

    // A new underflow beats a same-cycle clear.
    if (enable && smp_stb && !hold_full_q) underflow_d = 1'b1;
    else if (underflow_clr)                underflow_d = 1'b0;

    if (!enable) begin
      bit_cnt_d   = '0;
      osr_cnt_d   = '0;
      hold_reg_d  = '0;
      hold_full_d = 1'b0;
      act_reg_d   = '0;
    end else begin
      bit_cnt_d = bit_stb ? '0 : bit_cnt_q + 1'b1;
      if (bit_stb) osr_cnt_d = (osr_cnt_q == OSR_LAST) ? '0 : osr_cnt_q + 1'b1;
      if (smp_stb) begin
        if (hold_full_q) act_reg_d = hold_reg_q;
        hold_full_d = 1'b0;
      end
      if (handshake) begin
        hold_reg_d  = sample_in;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_q   <= '0;
      osr_cnt_q   <= '0;
      hold_reg_q  <= '0;
      hold_full_q <= 1'b0;
      act_reg_q   <= '0;
      aud_sd_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      osr_cnt_q   <= osr_cnt_d;
      hold_reg_q  <= hold_reg_d;
      hold_full_q <= hold_full_d;
      act_reg_q   <= act_reg_d;
      aud_sd_q    <= aud_sd_d;
      underflow_q <= underflow_d;
    end
  end

  pdm_sigma_delta u_mod (
    .clock   (clock),
    .reset   (reset),
    .clr     (!enable),
    .bit_stb (bit_stb),
    .sample  (act_reg_q),
    .pdm_bit (pdm_out)
  );

  assign sample_ready = ready;
  assign aud_sd       = aud_sd_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_pdm_audio_tx.sv
// tb/tb_pdm_audio_tx.sv - scoreboard bench for pdm_audio_tx, default build, BIT_DIV=32 OSR=64
module tb_pdm_audio_tx;

  localparam int BD = 32;
  localparam int SP = 32 * 64;

  logic        clock = 1'b0;
  logic        reset, enable, sample_valid, underflow_clr;
  logic [15:0] sample_in;
  logic        sample_ready, pdm_out, aud_sd, underflow;

  pdm_audio_tx dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .pdm_out       (pdm_out),
    .aud_sd        (aud_sd),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  always #5 clock = ~clock;

  typedef struct {
    int lo;
    int hi;
    bit alt;
    bit exact;
    bit uf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   run_cnt = 0;

  // Reference cycle count since the last reset/disable, sampled at the same edge as the DUT.
  always @(posedge clock) begin
    if (reset || !enable) run_cnt = 0;
    else run_cnt = run_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (run_cnt %0d)", name, act, exp, run_cnt);
    end
  endtask

  task automatic push(input int lo, input int hi, input bit alt, input bit exact, input bit uf);
    exp_t e;
    e.lo = lo; e.hi = hi; e.alt = alt; e.exact = exact; e.uf = uf;
    sb.push_back(e);
  endtask

  task automatic wait_run(input int target);
    int n = 0;
    while (run_cnt != target && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk("wait_run_bound", 32'(run_cnt), 32'(target));
  endtask

  task automatic send(input logic [15:0] v);
    int n = 0;
    sample_valid = 1'b1;
    sample_in    = v;
    while (!sample_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk("send_ready_bound", 32'(n < 5000), 32'd1);
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  // Monitor: collects one PDM bit per BD clocks and checks each completed sample period.
  int   ones = 0, alt_err = 0, exact_err = 0, hold_err = 0, per_idx = 0;
  logic cur = 1'b0, prev = 1'b0;

  always @(negedge clock) begin
    int   phase, bi;
    exp_t e;
    if (run_cnt < BD) begin
      ones = 0; alt_err = 0; exact_err = 0; hold_err = 0;
    end else begin
      phase = run_cnt % BD;
      bi    = (run_cnt / BD - 1) % 64;
      if (phase == 0) cur = pdm_out;
      else if (pdm_out !== cur) hold_err++;
      if (phase == BD - 1) begin
        ones += int'(cur);
        if (bi != 0 && cur == prev) alt_err++;
        if (cur != bi[0]) exact_err++;
        prev = cur;
        if (bi == 63) begin
          if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            n_cmp++;
            if (ones < e.lo || ones > e.hi) begin
              n_bad++;
              $display("FAIL period%0d_ones: got %0d want %0d..%0d", per_idx, ones, e.lo, e.hi);
            end
            chk($sformatf("period%0d_bit_hold", per_idx), 32'(hold_err), 32'd0);
            if (e.alt) chk($sformatf("period%0d_alternate", per_idx), 32'(alt_err), 32'd0);
            if (e.exact) chk($sformatf("period%0d_exact_pattern", per_idx), 32'(exact_err), 32'd0);
            chk($sformatf("period%0d_underflow", per_idx), 32'(underflow), 32'(e.uf));
          end
          per_idx++;
          ones = 0; alt_err = 0; exact_err = 0; hold_err = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; enable = 1'b1; sample_valid = 1'b0; underflow_clr = 1'b0; sample_in = '0;

    // Reset held for 5 clocks with enable high.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rst_pdm_out", 32'(pdm_out), 32'd0);
      chk("rst_aud_sd", 32'(aud_sd), 32'd0);
      chk("rst_sample_ready", 32'(sample_ready), 32'd0);
      chk("rst_underflow", 32'(underflow), 32'd0);
    end
    reset = 1'b0;
    push(32, 32, 1, 1, 0);
    #1;
    chk("rel_aud_sd_not_yet", 32'(aud_sd), 32'd0);
    @(negedge clock);
    chk("rel_aud_sd", 32'(aud_sd), 32'd1);
    chk("rel_sample_ready", 32'(sample_ready), 32'd1);

    // Back-to-back samples, each used in the following sample period.
    send(16'h0000); push(32, 32, 1, 0, 0);
    send(16'h0000); push(32, 32, 1, 0, 0);
    send(16'h8000); push(0, 0, 0, 0, 0);
    send(16'h7FFF); push(63, 64, 0, 0, 0);
    send(16'h4000); push(48, 48, 0, 0, 0);
    send(16'hC000); push(16, 16, 0, 0, 1);

    // Starved: last sample repeats, underflow sets; clear loses to a same-cycle set.
    push(16, 16, 0, 0, 1);
    wait_run(7 * SP + 500);
    underflow_clr = 1'b1;
    @(negedge clock);
    underflow_clr = 1'b0;
    chk("uf_clear", 32'(underflow), 32'd0);
    wait_run(8 * SP - 1);
    underflow_clr = 1'b1;
    @(negedge clock);
    underflow_clr = 1'b0;
    chk("uf_set_beats_clr", 32'(underflow), 32'd1);

    // Valid arriving on the sample strobe while the holding register is full.
    push(16, 16, 0, 0, 0);
    wait_run(8 * SP + 500);
    underflow_clr = 1'b1;
    @(negedge clock);
    underflow_clr = 1'b0;
    chk("uf_clear2", 32'(underflow), 32'd0);
    send(16'h4000);
    wait_run(9 * SP - 1);
    chk("ready_low_on_stb", 32'(sample_ready), 32'd0);
    send(16'h8000);
    push(48, 48, 0, 0, 0);
    push(0, 0, 0, 0, 1);
    chk("no_uf_after_stb", 32'(underflow), 32'd0);

    // Disable mid-period for 3 clocks with a sample waiting in the holding register.
    wait_run(11 * SP + 100);
    send(16'h7FFF);
    wait_run(11 * SP + 1000);
    enable = 1'b0;
    #1;
    chk("dis_sample_ready", 32'(sample_ready), 32'd0);
    @(negedge clock);
    chk("dis_pdm_out", 32'(pdm_out), 32'd0);
    chk("dis_aud_sd", 32'(aud_sd), 32'd0);
    chk("dis_underflow_kept", 32'(underflow), 32'd1);
    @(negedge clock);
    @(negedge clock);
    enable = 1'b1;
    push(32, 32, 1, 1, 1);
    push(32, 32, 1, 0, 1);
    #1;
    chk("re_aud_sd_not_yet", 32'(aud_sd), 32'd0);
    chk("re_sample_ready", 32'(sample_ready), 32'd1);
    @(negedge clock);
    chk("re_aud_sd", 32'(aud_sd), 32'd1);

    wait_run(2 * SP + 40);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
